// File: rtl/frame_tick_pacer_if.sv
// Avalon-MM 16-bit slave bus used by frame_tick_pacer for control, status
// and counter access.
interface frame_tick_pacer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/frame_tick_pacer.sv
// Divides timer ticks into frame-start requests with req/ack handshake,
// counts frames and overruns. Optional cycle timestamp: FRAME_PACER_TIMESTAMP_EN.
module frame_tick_pacer #(
    parameter logic [15:0] DIV_RESET = 16'd1,
    parameter int          OVR_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    frame_tick_pacer_if.slave   bus,
    input  logic                tick_in,
    input  logic                frame_ack,
    output logic                frame_req,
    output logic                irq
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]           state_q, state_d;
    logic                 tickDly_q;
    logic                 ien_q, ien_d;
    logic                 run_q, run_d;
    logic [15:0]          divider_q, divider_d;
    logic [15:0]          tickCnt_q, tickCnt_d;
    logic [31:0]          frameCount_q, frameCount_d;
    logic [15:0]          fcntShadow_q, fcntShadow_d;
    logic [OVR_WIDTH-1:0] ovrCount_q, ovrCount_d;
    logic                 frameFlag_q, frameFlag_d;
    logic                 overrun_q, overrun_d;
    logic                 irq_q, irq_d;
    logic [15:0]          readdata_q, readdata_d;

    logic        wrEn, rdEn, statusWr, ctrlWr, divWr, clrStrobe;
    logic        tickEdge, frameEvent, incFrame, incOvr;
    logic [15:0] divEff;
    logic [15:0] tsLow, tsHigh;

    assign wrEn      = bus.chipselect & ~bus.write_n;
    assign rdEn      = bus.chipselect &  bus.write_n;
    assign statusWr  = wrEn && (bus.address == 3'd0);
    assign ctrlWr    = wrEn && (bus.address == 3'd1);
    assign divWr     = wrEn && (bus.address == 3'd2);
    assign clrStrobe = ctrlWr & bus.writedata[2];

    assign tickEdge   = tick_in & ~tickDly_q;
    assign divEff     = (divider_q == 16'd0) ? 16'd1 : divider_q;
    assign frameEvent = run_q & tickEdge & (tickCnt_q == divEff - 16'd1);

    // Frame handshake: an event while a request is still pending is an overrun
    // unless the renderer acknowledges in that very cycle.
    always_comb begin
        state_d  = state_q;
        incFrame = 1'b0;
        incOvr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frameEvent) begin
                    state_d  = REQ;
                    incFrame = 1'b1;
                end
            end
            REQ: begin
                if (frameEvent) begin
                    incFrame = frame_ack;
                    incOvr   = ~frame_ack;
                end else if (frame_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tickCnt_d    = tickCnt_q;
        frameCount_d = frameCount_q;
        ovrCount_d   = ovrCount_q;
        frameFlag_d  = frameFlag_q;
        overrun_d    = overrun_q;
        ien_d        = ien_q;
        run_d        = run_q;
        divider_d    = divider_q;
        fcntShadow_d = fcntShadow_q;

        if (clrStrobe || divWr)
            tickCnt_d = 16'd0;
        else if (run_q && tickEdge)
            tickCnt_d = frameEvent ? 16'd0 : tickCnt_q + 16'd1;

        if (clrStrobe)
            frameCount_d = 32'd0;
        else if (incFrame)
            frameCount_d = frameCount_q + 32'd1;

        if (clrStrobe)
            ovrCount_d = '0;
        else if (incOvr && (ovrCount_q != {OVR_WIDTH{1'b1}}))
            ovrCount_d = ovrCount_q + 1'b1;

        // A flag being set outranks a simultaneous STATUS clear.
        if (incFrame)
            frameFlag_d = 1'b1;
        else if (statusWr)
            frameFlag_d = 1'b0;

        if (incOvr)
            overrun_d = 1'b1;
        else if (statusWr)
            overrun_d = 1'b0;

        if (ctrlWr) begin
            ien_d = bus.writedata[0];
            run_d = bus.writedata[1];
        end

        if (divWr)
            divider_d = bus.writedata;

        if (rdEn && (bus.address == 3'd3))
            fcntShadow_d = frameCount_q[31:16];
    end

    assign irq_d = ien_q & (frameFlag_q | overrun_q);

    always_comb begin
        readdata_d = 16'h0000;
        case (bus.address)
            3'd0:    readdata_d = {13'b0, overrun_q, frameFlag_q, state_q == REQ};
            3'd1:    readdata_d = {14'b0, run_q, ien_q};
            3'd2:    readdata_d = divider_q;
            3'd3:    readdata_d = frameCount_q[15:0];
            3'd4:    readdata_d = fcntShadow_q;
            3'd5:    readdata_d = 16'(ovrCount_q);
            3'd6:    readdata_d = tsLow;
            3'd7:    readdata_d = tsHigh;
            default: readdata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tickDly_q    <= 1'b0;
            ien_q        <= 1'b0;
            run_q        <= 1'b0;
            divider_q    <= DIV_RESET;
            tickCnt_q    <= 16'd0;
            frameCount_q <= 32'd0;
            fcntShadow_q <= 16'd0;
            ovrCount_q   <= '0;
            frameFlag_q  <= 1'b0;
            overrun_q    <= 1'b0;
            irq_q        <= 1'b0;
            readdata_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            tickDly_q    <= tick_in;
            ien_q        <= ien_d;
            run_q        <= run_d;
            divider_q    <= divider_d;
            tickCnt_q    <= tickCnt_d;
            frameCount_q <= frameCount_d;
            fcntShadow_q <= fcntShadow_d;
            ovrCount_q   <= ovrCount_d;
            frameFlag_q  <= frameFlag_d;
            overrun_q    <= overrun_d;
            irq_q        <= irq_d;
            readdata_q   <= readdata_d;
        end
    end

`ifdef FRAME_PACER_TIMESTAMP_EN
    logic [31:0] cycCnt_q, tsSnap_q;
    logic [15:0] tsShadow_q;

    // Free-running cycle count captured whenever a frame is counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycCnt_q   <= 32'd0;
            tsSnap_q   <= 32'd0;
            tsShadow_q <= 16'd0;
        end else begin
            cycCnt_q <= cycCnt_q + 32'd1;
            if (incFrame)
                tsSnap_q <= cycCnt_q;
            if (rdEn && (bus.address == 3'd6))
                tsShadow_q <= tsSnap_q[31:16];
        end
    end

    assign tsLow  = tsSnap_q[15:0];
    assign tsHigh = tsShadow_q;
`else
    assign tsLow  = 16'h0000;
    assign tsHigh = 16'h0000;
`endif

    assign bus.readdata = readdata_q;
    assign frame_req    = state_q;
    assign irq          = irq_q;

endmodule

// File: doc/frame_tick_pacer.md
Name: frame_tick_pacer

Overview:
Sits directly downstream of the interval timer. Consumes the timer's irq line as a tick source and divides ticks into frame-start requests for the LT24 render loop, using a req/ack handshake. Detects and counts frames the renderer could not keep up with (overruns). Avalon-MM 16-bit slave for control, status and counters; raises its own irq to the CPU.

Parameters:
DIV_RESET, 1, reset value of the divider register (ticks per frame)
OVR_WIDTH, 16, width of the saturating overrun counter (at most 16)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data, 1-cycle latency
tick_in  in  1  timer irq level; rising edge = one tick
frame_ack  in  1  renderer acknowledge pulse
frame_req  out  1  frame request; high until acknowledged
irq  out  1  CPU interrupt, level

Behaviour:
- Reset is asynchronous and active-high. All registers clear except divider, which takes DIV_RESET. Outputs reset to readdata=0, frame_req=0, irq=0.
- Tick detection: tick_d <= tick_in; tick_edge = tick_in & ~tick_d. tick_d resets to 0, so tick_in high during reset release gives an edge on the first cycle.
- Register map (wr = chipselect & ~write_n):
  - 0 STATUS, R: {13'b0, overrun, frame_flag, frame_req}. W (any data): clears overrun and frame_flag.
  - 1 CONTROL, R/W: bit0 ien, bit1 run. bit2 is a W-only clear strobe that zeroes frame_count, ovr_count and tick_cnt. bit2 reads 0.
  - 2 DIVIDER, R/W, 16-bit. Value 0 behaves as 1. Any write zeroes tick_cnt.
  - 3 FCNT_L: read returns frame_count[15:0] and latches frame_count[31:16] into a shadow register.
  - 4 FCNT_H: read returns the shadow. The read strobe is chipselect & write_n.
  - 5 OVR_CNT: read returns ovr_count, zero-extended.
  - 6, 7: see Optional Feature.
- Tick counter:
  - Counts only when run=1 and tick_edge. If run=0, edges are ignored and tick_cnt holds.
  - On an edge with tick_cnt == max(divider,1)-1: tick_cnt <= 0 and frame_event=1. Otherwise tick_cnt+1.
- Frame state machine, states IDLE (frame_req=0) and REQ (frame_req=1):
  - IDLE + frame_event: go to REQ; frame_count+1 (wraps at 2^32); frame_flag <= 1.
  - REQ + frame_ack, no event: go to IDLE next cycle.
  - REQ + frame_event, no ack: stay in REQ; overrun <= 1; ovr_count+1, saturating at 2^OVR_WIDTH-1; frame_count unchanged.
  - REQ + frame_ack + frame_event in the same cycle: stay in REQ; frame_count+1; frame_flag <= 1; no overrun.
  - IDLE + frame_ack: ignored.
  - Clearing run does not drop frame_req; a pending request still completes on ack.
- Simultaneous events:
  - Clear strobe and a counter increment in the same cycle: clear wins.
  - STATUS write and a flag set in the same cycle: set wins.
- irq = ien & (frame_flag | overrun), registered. It asserts 1 cycle after the flag sets.
- readdata is registered from the read mux every cycle, regardless of chipselect. Unmapped or disabled addresses read 0.

Optional Feature:
- Macro: FRAME_PACER_TIMESTAMP_EN.
- Defined: a 32-bit free-running cycle counter (reset 0, wraps) is snapshotted into ts_snap on every frame_count increment. Address 6 reads ts_snap[15:0] and latches ts_snap[31:16] into a shadow; address 7 reads the shadow.
- Undefined: no counter or snapshot logic; addresses 6 and 7 read 0.

Test Plan:
- Reset, then read all addresses -> DIVIDER=DIV_RESET (1), all others 0; frame_req=0, irq=0.
- DIVIDER=3, CONTROL=0x0003, 6 tick_in edges, ack each request within 2 cycles -> frame_req rises on edges 3 and 6; FCNT_L=2, OVR_CNT=0; irq high after first frame until a STATUS write clears it.
- DIVIDER=1, run, 3 edges with no ack -> frame_req stays 1; FCNT_L=1, OVR_CNT=2, STATUS=0x0007.
- frame_ack coincident with the next frame_event -> frame_req stays 1; frame_count increments; overrun stays 0.
- Force frame_count=0x0000FFFF then one more frame, read FCNT_L then FCNT_H -> 0x0000 then 0x0001. Write CONTROL bit2 -> both read 0.
- With FRAME_PACER_TIMESTAMP_EN defined: two frames 100 cycles apart -> addr 6/7 difference equals 100. Undefined -> addr 6/7 read 0.
